wb_lsu_master: RTL
==================

# wb_lsu_master

- Wishbone-style bus initiator for the core's load/store path.
- Accepts one load/store request at a time from the execute stage and drives a single bus cycle to the data memory responder.
- Waits for the acknowledge, guarded by a timeout, and returns one response to the writeback stage.
- Sits between the core pipeline and the memory/bus port, and uses the same sel encoding as the responder.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles from first `o_wb_stb` to `i_wb_ack` before an error response; range 1..65535.
- i_clk  in  1  clock. One clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_req_valid  in  1  core request present.
- o_req_ready  out  1  request accepted when valid&&ready; high only in IDLE.
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, LSB-aligned.
- i_req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000, 001, 010.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_rdata  out  32  load result, already extended by the responder; 0 for stores and errors.
- o_rsp_err  out  1  valid with o_rsp_valid. Set on timeout, illegal funct3, or a trapped misalignment.
- o_wb_stb  out  1  bus strobe.
- o_wb_we  out  1  bus write enable.
- o_wb_addr  out  32  bus address (= i_req_addr).
- o_wb_data  out  32  bus write data.
- o_wb_sel  out  3  size code; equals funct3.
- i_wb_data  in  32  bus read data.
- i_wb_ack  in  1  bus acknowledge.
- i_wb_stall  in  1  bus stall.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - o_req_ready=1.
  - On valid&&ready, capture we/addr/wdata/funct3 and clear the timeout counter.
  - Illegal request (funct3 ∈ {011,110,111}, or we=1 with funct3 ∈ {100,101}): go to RESP with err=1. No bus cycle.
  - Otherwise go to REQ.
- REQ:
  - o_wb_stb=1; addr/data/we/sel stay stable.
  - Counter increments each cycle.
  - On stb&&!i_wb_stall (transfer accepted), go to WAIT.
- WAIT:
  - o_wb_stb=0.
  - On i_wb_ack, capture i_wb_data (loads only) and go to RESP with err=0.
- Timeout: in REQ or WAIT, when the counter reaches TIMEOUT_CYCLES without an ack, go to RESP with err=1 and rdata=0. stb drops at the same time.
- RESP:
  - o_rsp_valid=1 for exactly one cycle, then IDLE.
  - RESP is never skipped. This guarantees at least one cycle with stb low after ack, because the responder ignores a strobe in its ack cycle.
- i_wb_ack outside WAIT (stray ack) is ignored with no state change.
- Simultaneous ack and timeout expiry in WAIT: the ack wins, err=0.
- Reset mid-operation: next state is IDLE, stb drops, no response is issued, and the captured request is discarded.

## Timing
- Reset values:
  - o_req_ready=1.
  - o_wb_stb=0, o_wb_we=0, o_wb_addr=0, o_wb_data=0, o_wb_sel=3'b000.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0.
- All bus outputs and response outputs are registered; o_req_ready is decoded from state.
- Cycle numbering for a request accepted at cycle 0:
  - o_wb_stb rises at cycle 1.
  - Ack seen at cycle N gives o_rsp_valid at cycle N+1.
  - o_req_ready returns high at cycle N+2.
- Against the memory responder (accepts at 1, acks at 3): o_rsp_valid at cycle 4, next request accepted at cycle 5.
- Illegal request: o_rsp_valid at cycle 1, err=1.
- Timeout counter is 16 bits and saturates; it never wraps.

## Configuration
- LSU_MISALIGN_TRAP_EN:
  - Defined: a misaligned request is treated as illegal, giving err=1 in RESP with no bus cycle. Misaligned means a word with addr[1:0]≠00, or a half with addr[0]=1.
  - Undefined: misaligned requests are forwarded unchanged; the responder handles the split, including a half at offset 3.

## Test plan
- LW at 0x100 (memory word 0xDEADBEEF), zero-stall responder acking 2 cycles after accept -> stb held exactly 1 cycle; o_rsp_valid at cycle 4 with rdata=0xDEADBEEF, err=0.
- SB of 0xA5 to 0x203, then LBU from 0x203 -> store response rdata=0, err=0; load rdata=0x000000A5. Between the two, stb stays low on the ack cycle and the cycle after it.
- i_wb_stall held high for 5 cycles -> stb stays high with addr/sel stable for 6 cycles; transfer is accepted only on the first stall-low cycle.
- TIMEOUT_CYCLES=8, responder never acks -> o_rsp_valid with err=1, rdata=0 exactly 9 cycles after stb rises; FSM then back to IDLE with o_req_ready=1.
- funct3=011, and store with funct3=101 -> each gives err=1 one cycle after accept with no stb. LH at 0x101 with macro defined -> err=1, no stb; macro undefined -> bus cycle issued with sel=001.
- Assert i_reset in WAIT -> stb=0, no o_rsp_valid, o_req_ready=1 on the next cycle. A late ack afterwards is ignored.

Source files
------------

// File: rtl/wb_lsu_master.sv
// Purpose : Wishbone-style bus initiator for the core load/store path. It takes one
//           request at a time, runs one bus cycle with a timeout, and returns one response.
// Latency : accept at cycle 0, stb from cycle 1, ack at cycle N gives rsp at N+1 and ready at N+2.
// Backpr. : o_req_ready is high only in IDLE. The bus stalls via i_wb_stall. The response
//           strobe cannot be stalled.
//
// Ports   : i_clk/i_reset (sync, active-high); request i_req_* with o_req_ready;
//           response o_rsp_valid/o_rsp_rdata/o_rsp_err; bus o_wb_* and i_wb_data/ack/stall.
// Option  : LSU_MISALIGN_TRAP_EN. When it is defined, misaligned half/word requests are
//           rejected as illegal. When it is not defined, they go to the bus unchanged.
module wb_lsu_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [2:0]  i_req_funct3,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [2:0]  o_wb_sel,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_stb_q, wb_stb_d;
    logic        wb_we_q, wb_we_d;
    logic [31:0] wb_addr_q, wb_addr_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [2:0]  wb_sel_q, wb_sel_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic        req_misalign;
    logic        req_illegal;
    logic        cnt_expired;
    logic [15:0] cnt_inc;

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0] is the access size: 01 = half, 10 = word.
    assign req_misalign = ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)) ||
                          ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]);
`else
    assign req_misalign = 1'b0;
`endif

    // Illegal encodings are 011, 11x, and unsigned (10x) forms used on a store.
    assign req_illegal = (i_req_funct3 == 3'b011) ||
                         (i_req_funct3[2:1] == 2'b11) ||
                         (i_req_we && (i_req_funct3[2:1] == 2'b10)) ||
                         req_misalign;

    // The counter is cleared on accept, so it holds k-1 in the k-th cycle after accept.
    // Expiry therefore puts RESP exactly TIMEOUT_CYCLES+1 cycles after stb rises.
    assign cnt_expired = (cnt_q >= TIMEOUT_LIM);
    assign cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : (cnt_q + 16'd1);

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_wb_stb    = wb_stb_q;
    assign o_wb_we     = wb_we_q;
    assign o_wb_addr   = wb_addr_q;
    assign o_wb_data   = wb_data_q;
    assign o_wb_sel    = wb_sel_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wb_stb_d    = 1'b0;
        wb_we_d     = wb_we_q;
        wb_addr_d   = wb_addr_q;
        wb_data_d   = wb_data_q;
        wb_sel_d    = wb_sel_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    wb_we_d   = i_req_we;
                    wb_addr_d = i_req_addr;
                    wb_data_d = i_req_wdata;
                    wb_sel_d  = i_req_funct3;
                    cnt_d     = 16'd0;
                    if (req_illegal) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d  = ST_REQ;
                        wb_stb_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // If expiry and acceptance happen together, the cycle is abandoned.
                // A late ack then arrives outside WAIT and is ignored.
                if (cnt_expired) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (i_wb_stall) begin
                    wb_stb_d = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                // The ack takes priority over an expiry in the same cycle.
                if (i_wb_ack) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wb_we_q ? 32'd0 : i_wb_data;
                end else if (cnt_expired) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ST_RESP: begin
                // This state is always visited, so stb stays low for at least one cycle after an ack.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= 32'd0;
            wb_data_q   <= 32'd0;
            wb_sel_q    <= 3'b000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wb_stb_q    <= wb_stb_d;
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            wb_sel_q    <= wb_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

endmodule
